mole_spawner: RTL and testbench
===============================

// Module: mole_spawner
// PURPOSE
//  Consumer of the free-running 5-bit random index: turns it into timed mole appearances
//  for the whack-a-mole game. Samples the index at each spawn, lights one hole (one-hot),
//  watches the player buttons for a hit, and reports hit/miss pulses and a running score.
//  Sits between the random generator, the debounced button inputs and the LED/score display.
// PARAMETERS
//  HOLE_W      4    hole index width; NUM_HOLES = 2**HOLE_W (1..5)
//  GAP_CYCLES  4    cycles with no mole between spawns (>=1)
//  UP_CYCLES   8    cycles a mole stays lit if not hit (>=1)
//  ROUNDS      3    moles per game (>=1)
//  SCORE_W     8    score width; saturating
// PORTS
//  clk        in   1          system clock, all logic on posedge
//  rst_n      in   1          synchronous reset, active-low
//  rand_val   in   5          random index from generator, sampled only at spawn
//  start      in   1          pulse: begin a game (ignored while busy)
//  abort      in   1          level: end game immediately
//  whack      in   NUM_HOLES  debounced button levels, one per hole
//  mole       out  NUM_HOLES  one-hot lit hole, 0 when no mole
//  hit        out  1          1-cycle pulse: correct hole struck
//  miss       out  1          1-cycle pulse: wrong hole struck or mole timed out
//  done       out  1          1-cycle pulse: game finished after ROUNDS moles
//  busy       out  1          high in GAP/UP
//  score      out  SCORE_W    hits this game
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): state IDLE; mole/hit/miss/done/busy=0; score=0; round=0;
//   timer=0; last_hole=0; whack_q<=whack (buttons held through reset make no edge).
//  Edge detect: strike = whack & ~whack_q, whack_q registered every cycle.
//  States IDLE, GAP, UP. All outputs registered.
//  IDLE: start=1 -> GAP, timer=GAP_CYCLES-1, score=0, round=0, busy=1.
//  GAP: timer!=0 -> decrement. timer==0 -> spawn: h_raw=rand_val[HOLE_W-1:0];
//   h = (h_raw==last_hole) ? h_raw+1 (mod NUM_HOLES) : h_raw; mole=1<<h; last_hole=h;
//   timer=UP_CYCLES-1 -> UP. Mole lights exactly GAP_CYCLES cycles after the start edge.
//  UP, priority per cycle:
//   1 strike[h]=1 (other strikes this cycle ignored): hit=1, score+=1 (saturate at
//     all-ones), mole=0, round+=1.
//   2 else timer==0: miss=1, mole=0, round+=1 (hit beats timeout in same cycle).
//   3 else any strike on unlit hole: miss=1, mole stays, timer keeps counting.
//   4 else timer decrements.
//   After 1 or 2: if round now == ROUNDS -> IDLE, done=1, busy=0; else GAP, timer=GAP_CYCLES-1.
//   Unhit mole is lit exactly UP_CYCLES cycles.
//  abort=1 in any state: next cycle IDLE, mole=0, busy=0, no hit/miss/done pulse; score held.
//   abort has priority over start and over UP events.
//  start while busy: ignored. Score held in IDLE until next start.
//  rand_val bits above HOLE_W-1 unused; index 0 and wrap (h_raw=NUM_HOLES-1 -> 0) legal.
// TESTING (GAP=4, UP=8, ROUNDS=3, HOLE_W=4)
//  1 Spawn: reset, rand_val=7, start 1 cycle -> mole=16'h0080 exactly 4 cycles later, busy=1.
//  2 Hit: rise whack[7] 3 cycles into UP -> hit 1 cycle, score=1, mole=0 same edge, next
//    mole 4 cycles later.
//  3 Timeout/dup: rand_val=7 again -> mole=16'h0100; no whack -> lit 8 cycles, miss 1 cycle,
//    score stays 1; whack[3] during UP -> miss, mole stays; whack[h] on timer==0 -> hit only.
//  4 Game end: 3rd mole resolves -> done 1 cycle, busy=0, score held; start again -> score=0.
//  5 Abort/reset: abort mid-UP -> IDLE next cycle, mole=0, no pulses; rst_n low mid-UP with
//    whack[h] held high through release -> all outputs 0, no hit after release.
//  6 Saturation: SCORE_W=2, ROUNDS=5, 5 hits -> score stops at 3, hit still pulses.

Source files
------------

// File: rtl/mole_spawner.sv
// mole_spawner: turns the free-running random index into timed mole
// appearances, watches the player buttons for hits and keeps a saturating
// per-game score. All outputs are registered.
module mole_spawner #(
    parameter int HOLE_W     = 4,
    parameter int GAP_CYCLES = 4,
    parameter int UP_CYCLES  = 8,
    parameter int ROUNDS     = 3,
    parameter int SCORE_W    = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [4:0]             rand_val,
    input  logic                   start,
    input  logic                   abort,
    input  logic [(2**HOLE_W)-1:0] whack,
    output logic [(2**HOLE_W)-1:0] mole,
    output logic                   hit,
    output logic                   miss,
    output logic                   done,
    output logic                   busy,
    output logic [SCORE_W-1:0]     score
);

    localparam int NUM_HOLES = 2**HOLE_W;
    localparam int MAX_T     = (GAP_CYCLES > UP_CYCLES) ? GAP_CYCLES : UP_CYCLES;
    localparam int TIMER_W   = (MAX_T > 1) ? $clog2(MAX_T) : 1;
    localparam int ROUND_W   = $clog2(ROUNDS + 1);

    localparam logic [TIMER_W-1:0] GAP_LOAD   = TIMER_W'(GAP_CYCLES - 1);
    localparam logic [TIMER_W-1:0] UP_LOAD    = TIMER_W'(UP_CYCLES - 1);
    localparam logic [ROUND_W-1:0] ROUND_LAST = ROUND_W'(ROUNDS);

    typedef enum logic [1:0] {
        IDLE,
        GAP,
        UP
    } state_t;

    state_t state, state_next;

    logic [TIMER_W-1:0]   timer, timer_next;
    logic [ROUND_W-1:0]   round, round_next;
    logic [HOLE_W-1:0]    last_hole, last_hole_next;
    logic [NUM_HOLES-1:0] whack_q;
    logic [NUM_HOLES-1:0] mole_next;
    logic                 hit_next, miss_next, done_next, busy_next;
    logic [SCORE_W-1:0]   score_next;

    logic [NUM_HOLES-1:0] strike;
    logic                 hit_ev, wrong_ev, timeout, last_round;
    logic [ROUND_W-1:0]   round_inc;
    logic [HOLE_W-1:0]    h_raw, h_spawn;
    logic                 unused_rand;

    // Upper random bits are intentionally ignored when HOLE_W < 5.
    assign unused_rand = ^rand_val;

    assign strike     = whack & ~whack_q;
    assign hit_ev     = |(strike & mole);
    assign wrong_ev   = |(strike & ~mole);
    assign timeout    = (timer == '0);
    assign round_inc  = round + 1'b1;
    assign last_round = (round_inc == ROUND_LAST);
    assign h_raw      = rand_val[HOLE_W-1:0];
    // Never light the same hole twice in a row; wraps naturally at HOLE_W bits.
    assign h_spawn    = (h_raw == last_hole) ? h_raw + 1'b1 : h_raw;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state selection; abort overrides everything else
    always_comb begin
        state_next = state;
        if (abort) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: if (start) state_next = GAP;
                GAP:  if (timeout) state_next = UP;
                UP: begin
                    if (hit_ev || timeout) begin
                        state_next = last_round ? IDLE : GAP;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Next values of timer, counters and registered outputs
    always_comb begin
        timer_next     = timer;
        round_next     = round;
        last_hole_next = last_hole;
        mole_next      = mole;
        hit_next       = 1'b0;
        miss_next      = 1'b0;
        done_next      = 1'b0;
        busy_next      = busy;
        score_next     = score;
        if (abort) begin
            timer_next = '0;
            mole_next  = '0;
            busy_next  = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        timer_next = GAP_LOAD;
                        score_next = '0;
                        round_next = '0;
                        busy_next  = 1'b1;
                    end
                end
                GAP: begin
                    if (timeout) begin
                        mole_next          = '0;
                        mole_next[h_spawn] = 1'b1;
                        last_hole_next     = h_spawn;
                        timer_next         = UP_LOAD;
                    end else begin
                        timer_next = timer - 1'b1;
                    end
                end
                UP: begin
                    // A correct strike wins over a simultaneous timeout.
                    if (hit_ev || timeout) begin
                        hit_next   = hit_ev;
                        miss_next  = ~hit_ev;
                        mole_next  = '0;
                        round_next = round_inc;
                        if (hit_ev && (score != '1)) begin
                            score_next = score + 1'b1;
                        end
                        if (last_round) begin
                            done_next = 1'b1;
                            busy_next = 1'b0;
                        end else begin
                            timer_next = GAP_LOAD;
                        end
                    end else begin
                        miss_next  = wrong_ev;
                        timer_next = timer - 1'b1;
                    end
                end
                default: begin
                    mole_next = '0;
                    busy_next = 1'b0;
                end
            endcase
        end
    end

    // Datapath and output registers; button history tracks inputs even in reset
    always_ff @(posedge clk) begin
        whack_q <= whack;
        if (!rst_n) begin
            timer     <= '0;
            round     <= '0;
            last_hole <= '0;
            mole      <= '0;
            hit       <= 1'b0;
            miss      <= 1'b0;
            done      <= 1'b0;
            busy      <= 1'b0;
            score     <= '0;
        end else begin
            timer     <= timer_next;
            round     <= round_next;
            last_hole <= last_hole_next;
            mole      <= mole_next;
            hit       <= hit_next;
            miss      <= miss_next;
            done      <= done_next;
            busy      <= busy_next;
            score     <= score_next;
        end
    end

endmodule

// File: tb/tb_mole_spawner.sv
// Directed bench for mole_spawner: a cycle-by-cycle vector table for the
// spawn/hit/timeout/game-end flow, then hand sequences for abort, reset with
// a held button, and score saturation on a second instance.
module tb_mole_spawner;

    logic        clk = 1'b0;
    logic        rst_n, start, abort, start2;
    logic [4:0]  rand_val;
    logic [15:0] whack, whack2;
    logic [15:0] mole, mole2;
    logic        hit, miss, done, busy;
    logic        hit2, miss2, done2, busy2;
    logic [7:0]  score;
    logic [1:0]  score2;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mole_spawner #(
        .HOLE_W(4), .GAP_CYCLES(4), .UP_CYCLES(8), .ROUNDS(3), .SCORE_W(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .rand_val(rand_val), .start(start),
        .abort(abort), .whack(whack), .mole(mole), .hit(hit), .miss(miss),
        .done(done), .busy(busy), .score(score)
    );

    mole_spawner #(
        .HOLE_W(4), .GAP_CYCLES(4), .UP_CYCLES(8), .ROUNDS(5), .SCORE_W(2)
    ) dut_sat (
        .clk(clk), .rst_n(rst_n), .rand_val(rand_val), .start(start2),
        .abort(abort), .whack(whack2), .mole(mole2), .hit(hit2), .miss(miss2),
        .done(done2), .busy(busy2), .score(score2)
    );

    typedef struct {
        logic        r, st, ab;
        logic [4:0]  rv;
        logic [15:0] wh;
        logic [15:0] m;
        logic        h, mi, d, b;
        logic [7:0]  s;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [31:0] pk(input logic [15:0] m, input logic h, mi, d, b,
                                       input logic [7:0] s);
        return {4'b0, m, h, mi, d, b, s};
    endfunction

    task automatic add(input logic r, st, ab, input logic [4:0] rv, input logic [15:0] wh,
                       input logic [15:0] m, input logic h, mi, d, b, input logic [7:0] s);
        vec_t v;
        v.r = r; v.st = st; v.ab = ab; v.rv = rv; v.wh = wh;
        v.m = m; v.h = h; v.mi = mi; v.d = d; v.b = b; v.s = s;
        vecs.push_back(v);
    endtask

    task automatic cmp(input string name, input int idx, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s[%0d]: got {mole,hit,miss,done,busy,score}=%h expected %h",
                     name, idx, got, exp);
        end
    endtask

    // One clock: drive main inputs at negedge, sample 1 time unit after posedge.
    task automatic step(input logic r, st, ab, input logic [4:0] rv, input logic [15:0] wh);
        @(negedge clk);
        rst_n = r; start = st; abort = ab; rand_val = rv; whack = wh;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_main(input string name, input int idx, input logic [15:0] m,
                               input logic h, mi, d, b, input logic [7:0] s);
        cmp(name, idx, pk(mole, hit, miss, done, busy, score), pk(m, h, mi, d, b, s));
    endtask

    task automatic expect_sat(input string name, input int idx, input logic [15:0] m,
                              input logic h, mi, d, b, input logic [1:0] s);
        cmp(name, idx, pk(mole2, hit2, miss2, done2, busy2, {6'b0, score2}),
            pk(m, h, mi, d, b, {6'b0, s}));
    endtask

    initial begin
        logic [3:0] last2;
        logic [3:0] h2;
        logic [1:0] s2;

        rst_n = 1'b0; start = 1'b0; abort = 1'b0; rand_val = '0; whack = '0;
        start2 = 1'b0; whack2 = '0;

        // reset
        add(0,0,0,0,16'h0, 16'h0,0,0,0,0,0);
        add(0,0,0,0,16'h0, 16'h0,0,0,0,0,0);
        // start, 3 gap cycles, spawn hole 7 on the 4th edge
        add(1,1,0,7,16'h0, 16'h0,0,0,0,1,0);
        for (int i = 0; i < 3; i++) add(1,0,0,7,16'h0, 16'h0,0,0,0,1,0);
        for (int i = 0; i < 3; i++) add(1,0,0,7,16'h0, 16'h0080,0,0,0,1,0);
        // hit on hole 7
        add(1,0,0,7,16'h0080, 16'h0,1,0,0,1,1);
        for (int i = 0; i < 3; i++) add(1,0,0,7,16'h0, 16'h0,0,0,0,1,1);
        // duplicate index 7 bumps to hole 8
        for (int i = 0; i < 2; i++) add(1,0,0,7,16'h0, 16'h0100,0,0,0,1,1);
        // wrong-hole strike: miss, mole stays
        add(1,0,0,7,16'h0008, 16'h0100,0,1,0,1,1);
        for (int i = 0; i < 5; i++) add(1,0,0,7,16'h0, 16'h0100,0,0,0,1,1);
        // timeout after 8 lit cycles
        add(1,0,0,7,16'h0, 16'h0,0,1,0,1,1);
        for (int i = 0; i < 3; i++) add(1,0,0,2,16'h0, 16'h0,0,0,0,1,1);
        for (int i = 0; i < 8; i++) add(1,0,0,2,16'h0, 16'h0004,0,0,0,1,1);
        // hit exactly on timer==0 of the last round: hit only, done
        add(1,0,0,2,16'h0004, 16'h0,1,0,1,0,2);
        add(1,0,0,2,16'h0, 16'h0,0,0,0,0,2);
        // restart clears score
        add(1,1,0,5,16'h0, 16'h0,0,0,0,1,0);

        foreach (vecs[i]) begin
            step(vecs[i].r, vecs[i].st, vecs[i].ab, vecs[i].rv, vecs[i].wh);
            expect_main("vec", i, vecs[i].m, vecs[i].h, vecs[i].mi, vecs[i].d,
                        vecs[i].b, vecs[i].s);
        end

        // abort during UP, with a simultaneous correct strike
        for (int i = 0; i < 3; i++) begin
            step(1,0,0,5,16'h0); expect_main("abort_gap", i, 16'h0,0,0,0,1,0);
        end
        step(1,0,0,5,16'h0);    expect_main("abort_spawn", 0, 16'h0020,0,0,0,1,0);
        step(1,0,0,5,16'h0020); expect_main("abort_hit", 0, 16'h0,1,0,0,1,1);
        for (int i = 0; i < 3; i++) begin
            step(1,0,0,5,16'h0); expect_main("abort_gap2", i, 16'h0,0,0,0,1,1);
        end
        step(1,0,0,5,16'h0);    expect_main("abort_spawn2", 0, 16'h0040,0,0,0,1,1);
        step(1,0,1,5,16'h0040); expect_main("abort_up", 0, 16'h0,0,0,0,0,1);
        step(1,1,1,5,16'h0040); expect_main("abort_over_start", 0, 16'h0,0,0,0,0,1);
        step(1,0,0,5,16'h0040); expect_main("abort_idle", 0, 16'h0,0,0,0,0,1);

        // reset mid-UP with the lit button held through release
        step(1,1,0,9,16'h0);    expect_main("rst_start", 0, 16'h0,0,0,0,1,0);
        for (int i = 0; i < 3; i++) begin
            step(1,0,0,9,16'h0); expect_main("rst_gap", i, 16'h0,0,0,0,1,0);
        end
        step(1,0,0,9,16'h0);    expect_main("rst_spawn", 0, 16'h0200,0,0,0,1,0);
        step(0,0,0,9,16'h0200); expect_main("rst_low", 0, 16'h0,0,0,0,0,0);
        step(0,0,0,9,16'h0200); expect_main("rst_low", 1, 16'h0,0,0,0,0,0);
        step(1,0,0,9,16'h0200); expect_main("rst_release", 0, 16'h0,0,0,0,0,0);
        step(1,1,0,9,16'h0200); expect_main("rst_restart", 0, 16'h0,0,0,0,1,0);
        for (int i = 0; i < 3; i++) begin
            step(1,0,0,9,16'h0200); expect_main("rst_gap2", i, 16'h0,0,0,0,1,0);
        end
        step(1,0,0,9,16'h0200); expect_main("rst_spawn2", 0, 16'h0200,0,0,0,1,0);
        for (int i = 0; i < 3; i++) begin
            step(1,0,0,9,16'h0200); expect_main("held_no_hit", i, 16'h0200,0,0,0,1,0);
        end
        step(1,0,1,9,16'h0);    expect_main("rst_abort", 0, 16'h0,0,0,0,0,0);

        // saturation on the SCORE_W=2, ROUNDS=5 instance
        last2 = 4'd0;
        s2    = 2'd0;
        start2 = 1'b1;
        step(1,0,0,3,16'h0);
        start2 = 1'b0;
        expect_sat("sat_start", 0, 16'h0,0,0,0,1,0);
        for (int k = 1; k <= 5; k++) begin
            for (int i = 0; i < 3; i++) step(1,0,0,3,16'h0);
            h2 = (4'd3 == last2) ? 4'd4 : 4'd3;
            last2 = h2;
            step(1,0,0,3,16'h0);
            expect_sat("sat_spawn", k, 16'h1 << h2, 0,0,0,1, s2);
            whack2 = 16'h1 << h2;
            step(1,0,0,3,16'h0);
            whack2 = '0;
            if (s2 != 2'd3) s2 = s2 + 2'd1;
            expect_sat("sat_hit", k, 16'h0, 1,0, (k == 5), (k != 5), s2);
        end
        step(1,0,0,3,16'h0);
        expect_sat("sat_hold", 0, 16'h0,0,0,0,0,2'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
